icache_refill_ctrl: RTL and testbench

//  I-cache miss/refill sequencer. Accepts one miss from the fetch-side lookup stage and issues a line-aligned

---
 rtl/icache_refill_ctrl.sv | 168 ++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
//
// I-cache miss/refill sequencer. Accepts one miss at a time from the fetch-side
// lookup stage, issues a line-aligned read to the memory port, collects
// LINE/MEM_DW response beats into a line buffer and writes the assembled line
// into a round-robin victim way of the tag/data arrays.
//
// Ports
//   clk_i, rst_ni      clock, synchronous active-low reset
//   flush_i            cancels the in-flight refill (fence.i / redirect)
//   miss_valid_i/_ready_o, miss_paddr_i   miss handshake and physical address
//   mem_req_valid_o/_ready_i, mem_req_addr_o   line-aligned read request
//   mem_rsp_valid_i, mem_rsp_data_i       response beats, beat 0 = lowest addr
//   refill_we_o        one-cycle array write strobe
//   refill_way_o/_index_o/_tag_o/_line_o  array write target and data
//   busy_o             controller is not idle
//
// Build option
//   ICACHE_REFILL_PERF_EN  adds perf_miss_cnt_o (committed refills) and
//                          perf_stall_cnt_o (cycles busy), both 32-bit wrapping.
//
// States
//   state   | meaning
//   IDLE    | ready for a miss
//   REQ     | read request presented, waiting for mem_req_ready_i
//   FILL    | collecting response beats into the line buffer
//   WRITE   | single-cycle write of the line into the victim way
// -----------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int PLEN               = 32,
    parameter int ICACHE_SET_ASSOC   = 4,
    parameter int ICACHE_INDEX_WIDTH = 6,
    parameter int ICACHE_LINE_WIDTH  = 512,
    parameter int MEM_DW             = 64,
    localparam int OFF_W   = $clog2(ICACHE_LINE_WIDTH / 8),
    localparam int INDEX_W = ICACHE_INDEX_WIDTH,
    localparam int TAG_W   = PLEN - INDEX_W - OFF_W,
    localparam int WAY_W   = $clog2(ICACHE_SET_ASSOC),
    localparam int LINE    = ICACHE_LINE_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               miss_valid_i,
    output logic               miss_ready_o,
    input  logic [PLEN-1:0]    miss_paddr_i,
    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    output logic [PLEN-1:0]    mem_req_addr_o,
    input  logic               mem_rsp_valid_i,
    input  logic [MEM_DW-1:0]  mem_rsp_data_i,
    output logic               refill_we_o,
    output logic [WAY_W-1:0]   refill_way_o,
    output logic [INDEX_W-1:0] refill_index_o,
    output logic [TAG_W-1:0]   refill_tag_o,
    output logic [LINE-1:0]    refill_line_o,
`ifdef ICACHE_REFILL_PERF_EN
    output logic [31:0]        perf_miss_cnt_o,
    output logic [31:0]        perf_stall_cnt_o,
`endif
    output logic               busy_o
);

    localparam int BEATS = LINE / MEM_DW;
    localparam int CNT_W = $clog2(BEATS) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    // Clears the byte-offset bits so the request is always line aligned.
    localparam logic [PLEN-1:0] ALIGN_MASK = {{(PLEN-OFF_W){1'b1}}, {OFF_W{1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] beat_cnt;
    logic [WAY_W-1:0] victim_ptr;
    logic             kill;
    logic [PLEN-1:0]  paddr_q;
    logic [LINE-1:0]  line_q;
    logic             last_beat;

    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= S_IDLE;
            beat_cnt   <= '0;
            victim_ptr <= '0;
            kill       <= 1'b0;
            paddr_q    <= '0;
            line_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // flush_i is deliberately ignored here: a miss arriving
                    // with the flush belongs to the redirected stream.
                    if (miss_valid_i) begin
                        paddr_q <= miss_paddr_i;
                        kill    <= 1'b0;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Once the request is accepted the beats will arrive
                    // regardless, so a flush can only mark the refill dead.
                    if (mem_req_ready_i) begin
                        beat_cnt <= '0;
                        kill     <= flush_i;
                        state    <= S_FILL;
                    end else if (flush_i) begin
                        state <= S_IDLE;
                    end
                end
                S_FILL: begin
                    if (flush_i) begin
                        kill <= 1'b1;
                    end
                    if (mem_rsp_valid_i) begin
                        for (int k = 0; k < BEATS; k++) begin
                            if (beat_cnt == CNT_W'(k)) begin
                                line_q[k*MEM_DW +: MEM_DW] <= mem_rsp_data_i;
                            end
                        end
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state <= (kill || flush_i) ? S_IDLE : S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    // The line is complete, so a flush here still commits.
                    victim_ptr <= victim_ptr + 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign miss_ready_o    = (state == S_IDLE);
    assign busy_o          = (state != S_IDLE);
    assign mem_req_valid_o = (state == S_REQ);
    assign mem_req_addr_o  = paddr_q & ALIGN_MASK;
    assign refill_we_o     = (state == S_WRITE);
    assign refill_way_o    = victim_ptr;
    assign refill_index_o  = paddr_q[OFF_W +: INDEX_W];
    assign refill_tag_o    = paddr_q[PLEN-1 -: TAG_W];
    assign refill_line_o   = line_q;

`ifdef ICACHE_REFILL_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_miss_cnt_o  <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (state == S_WRITE) begin
                perf_miss_cnt_o <= perf_miss_cnt_o + 32'd1;
            end
            if (state != S_IDLE) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         miss_valid;
    logic         miss_ready;
    logic [31:0]  miss_paddr;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         rsp_valid;
    logic [63:0]  rsp_data;
    logic         we;
    logic [1:0]   way;
    logic [5:0]   index;
    logic [19:0]  tag;
    logic [511:0] line;
    logic         busy;
`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0]  perf_miss;
    logic [31:0]  perf_stall;
`endif

    icache_refill_ctrl dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .miss_valid_i    (miss_valid),
        .miss_ready_o    (miss_ready),
        .miss_paddr_i    (miss_paddr),
        .mem_req_valid_o (req_valid),
        .mem_req_ready_i (req_ready),
        .mem_req_addr_o  (req_addr),
        .mem_rsp_valid_i (rsp_valid),
        .mem_rsp_data_i  (rsp_data),
        .refill_we_o     (we),
        .refill_way_o    (way),
        .refill_index_o  (index),
        .refill_tag_o    (tag),
        .refill_line_o   (line),
`ifdef ICACHE_REFILL_PERF_EN
        .perf_miss_cnt_o (perf_miss),
        .perf_stall_cnt_o(perf_stall),
`endif
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: where the current miss is in its life, plus
    // the round-robin victim as an integer modulo the associativity.
    bit           m_pending = 0;
    bit           m_filling = 0;
    bit           m_commit  = 0;
    bit           m_kill    = 0;
    int           m_beats   = 0;
    int           m_victim  = 0;
    logic [31:0]  m_addr    = '0;
    logic [511:0] m_line    = '0;
    int           m_misses  = 0;
    int           m_stall   = 0;

    function automatic bit m_busy();
        return m_pending || m_filling || m_commit;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pending <= 0; m_filling <= 0; m_commit <= 0; m_kill <= 0;
            m_beats <= 0; m_victim <= 0; m_addr <= '0;
            m_misses <= 0; m_stall <= 0;
        end else begin
            if (m_busy()) m_stall <= m_stall + 1;
            if (m_commit) begin
                m_commit <= 0;
                m_victim <= (m_victim + 1) % 4;
                m_misses <= m_misses + 1;
            end else if (m_pending) begin
                if (req_ready) begin
                    m_pending <= 0; m_filling <= 1; m_beats <= 0; m_kill <= flush;
                end else if (flush) begin
                    m_pending <= 0;
                end
            end else if (m_filling) begin
                if (flush) m_kill <= 1;
                if (rsp_valid) begin
                    m_line[m_beats*64 +: 64] <= rsp_data;
                    m_beats <= m_beats + 1;
                    if (m_beats == 7) begin
                        m_filling <= 0;
                        m_commit  <= !(m_kill || flush);
                    end
                end
            end else if (miss_valid) begin
                m_pending <= 1; m_addr <= miss_paddr;
            end
        end
    end

    // Captured DUT observations for the literal expectations.
    int          we_cnt = 0;
    int          last_we_cyc = 0;
    logic [31:0] last_req_addr = '0;
    logic [1:0]  last_way = '0;
    logic [5:0]  last_index = '0;
    logic [19:0] last_tag = '0;
    logic [511:0] last_line = '0;
    logic [1:0]  ways[$];

    always begin
        @(negedge clk);
        if (chk_en) begin
            chk("miss_ready", 512'(miss_ready), 512'(!m_busy()));
            chk("busy", 512'(busy), 512'(m_busy()));
            chk("req_valid", 512'(req_valid), 512'(m_pending));
            if (m_pending) chk("req_addr", 512'(req_addr), 512'((m_addr >> 6) << 6));
            chk("we", 512'(we), 512'(m_commit));
            if (m_commit) begin
                chk("way", 512'(way), 512'(m_victim));
                chk("index", 512'(index), 512'((m_addr >> 6) % 64));
                chk("tag", 512'(tag), 512'(m_addr >> 12));
                chk("line", line, m_line);
            end
`ifdef ICACHE_REFILL_PERF_EN
            chk("perf_miss", 512'(perf_miss), 512'(m_misses));
            chk("perf_stall", 512'(perf_stall), 512'(m_stall));
`endif
            if (req_valid) last_req_addr = req_addr;
            if (we) begin
                we_cnt++;
                last_we_cyc = cyc;
                last_way = way;
                last_index = index;
                last_tag = tag;
                last_line = line;
                ways.push_back(way);
            end
        end
    end

    int t_acc;

    // flush_beat: -1 none, 0..7 during that beat, 8 during the write cycle.
    task automatic run_refill(input logic [31:0] addr, input logic [63:0] base,
                              input int stall, input int flush_beat,
                              input bit flush_req, input bit flush_idle, input bit gap);
        miss_valid = 1; miss_paddr = addr; flush = flush_idle; t_acc = cyc;
        @(posedge clk); #1;
        miss_valid = 0; flush = 0; miss_paddr = 32'hFFFF_FFFF;
        if (flush_req && stall > 0) begin
            flush = 1;
            @(posedge clk); #1;
            flush = 0;
            return;
        end
        for (int i = 0; i < stall; i++) begin
            rsp_valid = (i == 1);
            rsp_data = 64'hDEAD_BEEF_0BAD_F00D;
            @(posedge clk); #1;
        end
        rsp_valid = 0;
        req_ready = 1; flush = flush_req;
        @(posedge clk); #1;
        req_ready = 0; flush = 0;
        for (int b = 0; b < 8; b++) begin
            rsp_valid = 1; rsp_data = base + 64'(b); flush = (b == flush_beat);
            @(posedge clk); #1;
            rsp_valid = 0; flush = 0;
            if (gap) begin
                @(posedge clk); #1;
            end
        end
        flush = (flush_beat == 8);
        @(posedge clk); #1;
        flush = 0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 0;
        repeat (n) begin
            @(posedge clk); #1;
        end
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    int n;

    initial begin
        rst_n = 0; flush = 0; miss_valid = 0; miss_paddr = '0;
        req_ready = 0; rsp_valid = 0; rsp_data = '0;
        do_reset(2);
        chk_en = 1;
        chk("rst_miss_ready", 512'(miss_ready), 512'(1));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_we", 512'(we), 512'(0));
        chk("rst_req_valid", 512'(req_valid), 512'(0));

        // basic refill with zero-wait memory
        run_refill(32'h8000_1234, 64'd0, 0, -1, 0, 0, 0);
        chk("t2_req_addr", 512'(last_req_addr), 512'(32'h8000_1200));
        chk("t2_we_latency", 512'(last_we_cyc), 512'(t_acc + 10));
        chk("t2_way", 512'(last_way), 512'(0));
        chk("t2_index", 512'(last_index), 512'(6'h08));
        chk("t2_tag", 512'(last_tag), 512'(20'h80001));
        chk("t2_line_top", 512'(last_line[511:448]), 512'(64'd7));
        chk("t2_ready_after", 512'(miss_ready), 512'(1));

        // five back-to-back misses to one index: ways 0,1,2,3,0
        do_reset(1);
        ways.delete();
        for (int i = 0; i < 5; i++)
            run_refill(32'h1000_0A40 + 32'(i) * 32'h1000_0000, 64'h1000 * 64'(i + 1), 0, -1, 0, 0, 0);
        chk("t3_count", 512'(ways.size()), 512'(5));
        for (int i = 0; i < 5 && i < ways.size(); i++)
            chk("t3_way_seq", 512'(ways[i]), 512'(i % 4));

        // stray beat in IDLE, then request stalled 5 cycles with a stray beat in REQ
        rsp_valid = 1; rsp_data = 64'hBAD0_BAD0_BAD0_BAD0;
        @(posedge clk); #1;
        rsp_valid = 0;
        run_refill(32'h0123_4567, 64'h100, 5, -1, 0, 0, 0);
        chk("t4_req_addr", 512'(last_req_addr), 512'(32'h0123_4540));
        chk("t4_we_latency", 512'(last_we_cyc), 512'(t_acc + 15));
        chk("t4_way", 512'(last_way), 512'(1));
        chk("t4_beat0", 512'(last_line[63:0]), 512'(64'h100));
        chk("t4_beat7", 512'(last_line[511:448]), 512'(64'h107));

        // flush at beat 3: no write, victim unchanged
        n = we_cnt;
        run_refill(32'h0000_2000, 64'h200, 0, 3, 0, 0, 0);
        chk("t5_no_we", 512'(we_cnt), 512'(n));
        chk("t5_ready", 512'(miss_ready), 512'(1));
        run_refill(32'h0000_3000, 64'h300, 0, -1, 0, 0, 1);
        chk("t5_next_way", 512'(last_way), 512'(2));

        // flush in REQ without accept, then with accept
        n = we_cnt;
        run_refill(32'h0000_4000, 64'h400, 2, -1, 1, 0, 0);
        chk("req_flush_idle", 512'(miss_ready), 512'(1));
        run_refill(32'h0000_5000, 64'h500, 0, -1, 1, 0, 0);
        chk("req_flush_kill", 512'(we_cnt), 512'(n));

        // flush during WRITE still commits, flush in IDLE does not block a miss
        run_refill(32'h0000_6000, 64'h600, 0, 8, 0, 0, 0);
        chk("write_flush_way", 512'(last_way), 512'(3));
        chk("write_flush_cnt", 512'(we_cnt), 512'(n + 1));
        run_refill(32'h0000_7040, 64'h700, 0, -1, 0, 1, 0);
        chk("idle_flush_way", 512'(last_way), 512'(0));
        chk("idle_flush_index", 512'(last_index), 512'(6'h01));

        // reset mid-fill returns to the reset state; victim back to 0
        miss_valid = 1; miss_paddr = 32'h0000_8000;
        @(posedge clk); #1;
        miss_valid = 0; req_ready = 1;
        @(posedge clk); #1;
        req_ready = 0;
        for (int b = 0; b < 3; b++) begin
            rsp_valid = 1; rsp_data = 64'(b);
            @(posedge clk); #1;
        end
        rsp_valid = 0;
        do_reset(1);
        chk("midrst_ready", 512'(miss_ready), 512'(1));
        chk("midrst_busy", 512'(busy), 512'(0));
        run_refill(32'h0000_9000, 64'h900, 0, -1, 0, 0, 0);
        chk("midrst_way", 512'(last_way), 512'(0));

`ifdef ICACHE_REFILL_PERF_EN
        do_reset(1);
        run_refill(32'h0000_A000, 64'hA00, 0, -1, 0, 0, 0);
        run_refill(32'h0000_B000, 64'hB00, 0, 3, 0, 0, 0);
        run_refill(32'h0000_C000, 64'hC00, 0, -1, 0, 0, 0);
        chk("perf_miss_total", 512'(perf_miss), 512'(2));
        chk("perf_stall_total", 512'(perf_stall), 512'(29));
`endif

        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
